// File: rtl/ppu_arb_pkg.sv
// Shared types and constants for the PPU VRAM arbiter and its address folding.
package ppu_arb_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_RENDER,
        SLOT_CPU
    } slot_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_RENDER,
        OWN_CPU
    } owner_t;

    localparam logic [13:0] PAL_BASE       = 14'h3F00;
    localparam logic [13:0] NT_MIRROR_BASE = 14'h3000;

endpackage

// File: rtl/ppu_addr_fold.sv
// Combinational PPU address mirror folding (palette and nametable mirrors).
// Compiled only when PPU_ARB_PALETTE_MIRROR_EN is defined.
`ifdef PPU_ARB_PALETTE_MIRROR_EN
module ppu_addr_fold
    import ppu_arb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] folded
);

    localparam logic [ADDR_W-1:0] PAL = ADDR_W'(PAL_BASE);
    localparam logic [ADDR_W-1:0] NT  = ADDR_W'(NT_MIRROR_BASE);

    always_comb begin
        folded = addr;
        if (addr >= PAL) begin
            // Sprite palette entry 0 of each group aliases the backdrop entries.
            folded = PAL | {{(ADDR_W-5){1'b0}}, addr[4:0]};
            if (addr[4] && (addr[1:0] == 2'b00)) begin
                folded[4] = 1'b0;
            end
        end else if (addr >= NT) begin
            folded = addr - ADDR_W'(14'h1000);
        end
    end

endmodule
`endif

// File: rtl/ppu_vram_arbiter.sv
// Shares the VRAM port between the render fetch engine and a buffered CPU access.
// Optional address mirror folding under PPU_ARB_PALETTE_MIRROR_EN.
module ppu_vram_arbiter
    import ppu_arb_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              render_req,
    input  logic [ADDR_W-1:0] render_addr,
    output logic              render_gnt,
    output logic              render_rvalid,
    output logic [7:0]        render_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic              buf_valid;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic [ADDR_W-1:0] last_addr;
    logic [WAIT_W-1:0] wait_cnt;
    owner_t            owner_q;
    logic [7:0]        render_rdata_q;
    logic [7:0]        cpu_rdata_q;
    slot_t             slot;
    logic [ADDR_W-1:0] render_addr_f;
    logic [ADDR_W-1:0] cpu_addr_f;

`ifdef PPU_ARB_PALETTE_MIRROR_EN
    ppu_addr_fold #(.ADDR_W(ADDR_W)) u_fold_render (.addr(render_addr), .folded(render_addr_f));
    ppu_addr_fold #(.ADDR_W(ADDR_W)) u_fold_cpu    (.addr(cpu_addr),    .folded(cpu_addr_f));
`else
    assign render_addr_f = render_addr;
    assign cpu_addr_f    = cpu_addr;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        slot = SLOT_IDLE;
        if (buf_valid && (!render_req || (wait_cnt == WAIT_MAX))) begin
            slot = SLOT_CPU;
        end else if (render_req) begin
            slot = SLOT_RENDER;
        end
    end

    always_comb begin
        render_gnt = 1'b0;
        ram_addr   = last_addr;
        ram_we     = 1'b0;
        ram_wdata  = 8'h00;
        case (slot)
            SLOT_RENDER: begin
                render_gnt = 1'b1;
                ram_addr   = render_addr_f;
            end
            SLOT_CPU: begin
                ram_addr  = buf_addr;
                ram_we    = buf_we;
                ram_wdata = buf_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid      <= 1'b0;
            buf_we         <= 1'b0;
            buf_addr       <= '0;
            buf_wdata      <= 8'h00;
            last_addr      <= '0;
            wait_cnt       <= '0;
            owner_q        <= OWN_NONE;
            render_rdata_q <= 8'h00;
            cpu_rdata_q    <= 8'h00;
        end else begin
            last_addr <= ram_addr;

            if (slot == SLOT_CPU) begin
                buf_valid <= 1'b0;
            end else if (cpu_req && !buf_valid) begin
                buf_valid <= 1'b1;
                buf_we    <= cpu_we;
                buf_addr  <= cpu_addr_f;
                buf_wdata <= cpu_wdata;
            end

            if (!buf_valid || (slot == SLOT_CPU)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (slot == SLOT_RENDER) begin
                owner_q <= OWN_RENDER;
            end else if ((slot == SLOT_CPU) && !buf_we) begin
                owner_q <= OWN_CPU;
            end else begin
                owner_q <= OWN_NONE;
            end

            if (owner_q == OWN_RENDER) render_rdata_q <= ram_rdata;
            if (owner_q == OWN_CPU)    cpu_rdata_q    <= ram_rdata;
        end
    end

    // Read data is forwarded straight from the RAM in its valid cycle and held afterwards.
    assign render_rvalid = (owner_q == OWN_RENDER);
    assign cpu_rvalid    = (owner_q == OWN_CPU);
    assign render_rdata  = render_rvalid ? ram_rdata : render_rdata_q;
    assign cpu_rdata     = cpu_rvalid    ? ram_rdata : cpu_rdata_q;
    assign cpu_busy      = buf_valid;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed self-checking bench for ppu_vram_arbiter with a synchronous VRAM model.
// Expectations for the mirror test follow PPU_ARB_PALETTE_MIRROR_EN.
module tb_ppu_vram_arbiter;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              render_req;
    logic [ADDR_W-1:0] render_addr;
    logic              render_gnt;
    logic              render_rvalid;
    logic [7:0]        render_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_busy;
    logic              cpu_rvalid;
    logic [7:0]        cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    ppu_vram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .render_req   (render_req),
        .render_addr  (render_addr),
        .render_gnt   (render_gnt),
        .render_rvalid(render_rvalid),
        .render_rdata (render_rdata),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_busy     (cpu_busy),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    // Synchronous single-port VRAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
        #1;
        check("wr_busy_capture", cpu_busy, 1'b0);
        step();
        cpu_req = 1'b0;
        #1;
        check("wr_busy_n1", cpu_busy, 1'b1);
        check("wr_we_n1", ram_we, 1'b1);
        check("wr_addr_n1", ram_addr, addr);
        check("wr_data_n1", ram_wdata, data);
        step();
        #1;
        check("wr_busy_n2", cpu_busy, 1'b0);
        check("wr_we_n2", ram_we, 1'b0);
        check("wr_addr_hold", ram_addr, addr);
        check("wr_no_rvalid", cpu_rvalid, 1'b0);
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] addr, input logic [7:0] expected);
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        #1;
        check("rd_busy_capture", cpu_busy, 1'b0);
        step();
        cpu_req = 1'b0;
        #1;
        check("rd_busy_slot", cpu_busy, 1'b1);
        check("rd_we_slot", ram_we, 1'b0);
        check("rd_addr_slot", ram_addr, addr);
        check("rd_rvalid_early", cpu_rvalid, 1'b0);
        step();
        #1;
        check("rd_rvalid", cpu_rvalid, 1'b1);
        check("rd_data", cpu_rdata, expected);
        check("rd_busy_after", cpu_busy, 1'b0);
        step();
        #1;
        check("rd_rvalid_pulse", cpu_rvalid, 1'b0);
        check("rd_data_held", cpu_rdata, expected);
    endtask

    // CPU write queued under continuous render traffic; must be forced in exactly 9 cycles later.
    task automatic starve_run(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        int lows;
        lows = 0;
        step();
        render_req = 1'b1; render_addr = 14'h0040;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
        #1;
        check("st_gnt_capture", render_gnt, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            step();
            cpu_req = 1'b0;
            #1;
            if (!render_gnt) lows++;
            check($sformatf("st_gnt_k%0d", k), render_gnt, (k != 9));
            check($sformatf("st_busy_k%0d", k), cpu_busy, (k <= 9));
            if (k == 9) begin
                check("st_forced_we", ram_we, 1'b1);
                check("st_forced_addr", ram_addr, addr);
            end
        end
        check("st_low_cycles", lows, 1);
        step();
        render_req = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = a[7:0];
        ram_rdata   = 8'h00;
        rst         = 1'b1;
        render_req  = 1'b0;
        render_addr = '0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = 8'h00;

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_gnt", render_gnt, 1'b0);
        check("rst_render_rvalid", render_rvalid, 1'b0);
        check("rst_render_rdata", render_rdata, 8'h00);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_ram_addr", ram_addr, 14'h0000);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_wdata", ram_wdata, 8'h00);

        // Render only: addresses 0x00..0x0F back to back
        for (int i = 0; i < 16; i++) begin
            step();
            render_req = 1'b1; render_addr = ADDR_W'(i);
            #1;
            check($sformatf("ro_gnt_%0d", i), render_gnt, 1'b1);
            check($sformatf("ro_addr_%0d", i), ram_addr, i);
            check($sformatf("ro_rvalid_%0d", i), render_rvalid, (i > 0));
            if (i > 0) check($sformatf("ro_rdata_%0d", i), render_rdata, i - 1);
        end
        step();
        render_req = 1'b0;
        #1;
        check("ro_rvalid_last", render_rvalid, 1'b1);
        check("ro_rdata_last", render_rdata, 8'h0F);
        check("ro_gnt_idle", render_gnt, 1'b0);
        step();
        #1;
        check("ro_rvalid_end", render_rvalid, 1'b0);
        check("ro_rdata_held", render_rdata, 8'h0F);

        // CPU write then read with render idle
        cpu_write(14'h2005, 8'hA5);
        cpu_read(14'h2005, 8'hA5);

        // Starvation bound, twice to show the wait counter restarts from zero
        starve_run(14'h0123, 8'h5C);
        starve_run(14'h0124, 8'hC3);
        cpu_read(14'h0123, 8'h5C);
        cpu_read(14'h0124, 8'hC3);

        // Busy drop: second request while the buffer is occupied is ignored
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2200; cpu_wdata = 8'h77;
        #1;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2100; cpu_wdata = 8'h99;
        #1;
        check("bd_busy", cpu_busy, 1'b1);
        check("bd_we_first", ram_we, 1'b1);
        check("bd_addr_first", ram_addr, 14'h2200);
        step();
        cpu_req = 1'b0;
        #1;
        check("bd_busy_clear", cpu_busy, 1'b0);
        check("bd_no_we", ram_we, 1'b0);
        check("bd_no_rvalid", cpu_rvalid, 1'b0);
        step();
        #1;
        check("bd_no_we2", ram_we, 1'b0);
        check("bd_no_rvalid2", cpu_rvalid, 1'b0);
        cpu_read(14'h2100, 8'h00);
        cpu_read(14'h2200, 8'h77);

        // Reset asserted in the CPU read slot cycle
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2200;
        #1;
        step();
        cpu_req = 1'b0; rst = 1'b1;
        #1;
        check("rm_busy_slot", cpu_busy, 1'b1);
        check("rm_we_slot", ram_we, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("rm_no_rvalid", cpu_rvalid, 1'b0);
        check("rm_busy", cpu_busy, 1'b0);
        check("rm_we", ram_we, 1'b0);
        check("rm_cpu_rdata", cpu_rdata, 8'h00);
        check("rm_ram_addr", ram_addr, 14'h0000);

        // Mirror folding (expectations depend on the build option)
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3F10; cpu_wdata = 8'h21;
        #1;
        step();
        cpu_req = 1'b0;
        #1;
        check("pm_we", ram_we, 1'b1);
`ifdef PPU_ARB_PALETTE_MIRROR_EN
        check("pm_wr_addr", ram_addr, 14'h3F00);
`else
        check("pm_wr_addr", ram_addr, 14'h3F10);
`endif
        step();
        render_req = 1'b1; render_addr = 14'h3F00;
        #1;
        check("pm_gnt", render_gnt, 1'b1);
        check("pm_rd_addr", ram_addr, 14'h3F00);
        step();
        render_addr = 14'h3123;
        #1;
        check("pm_rvalid", render_rvalid, 1'b1);
`ifdef PPU_ARB_PALETTE_MIRROR_EN
        check("pm_rdata", render_rdata, 8'h21);
        check("pm_nt_addr", ram_addr, 14'h2123);
`else
        check("pm_rdata", render_rdata, 8'h00);
        check("pm_nt_addr", ram_addr, 14'h3123);
`endif
        step();
        render_addr = 14'h3F2C;
        #1;
        check("pm_nt_rdata", render_rdata, 8'h23);
`ifdef PPU_ARB_PALETTE_MIRROR_EN
        check("pm_hi_addr", ram_addr, 14'h3F0C);
`else
        check("pm_hi_addr", ram_addr, 14'h3F2C);
`endif
        step();
        render_req = 1'b0;
        #1;
`ifdef PPU_ARB_PALETTE_MIRROR_EN
        check("pm_hi_rdata", render_rdata, 8'h0C);
`else
        check("pm_hi_rdata", render_rdata, 8'h2C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
